sar_ctrl: RTL

SAR_CTRL -- requirements
Module: sar_ctrl

---
 rtl/sar_ctrl_pkg.sv | 14 +
 rtl/sar_ctrl_edge_detect.sv | 27 ++
 rtl/sar_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sar_ctrl_pkg.sv
// Shared types and constants for the SAR conversion controller.
`timescale 1ns/1ps
package sar_ctrl_pkg;

  localparam int SAR_N_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } sar_state_t;

endpackage

// File: rtl/sar_ctrl_edge_detect.sv
// Single-bit edge detector: registers the level once and flags rise/fall
// against the previous registered value.
`timescale 1ns/1ps
module edge_detect (
  input  logic clk_in,
  input  logic rst_n,
  input  logic i_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_prev;

  // The previous value resets to 0, so a level already high at reset release
  // is reported as a rise on the first clock.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_level;
    end
  end

  assign o_rise = i_level & ~r_prev;
  assign o_fall = ~i_level & r_prev;

endmodule

// File: rtl/sar_ctrl.sv
// Successive-approximation ADC controller: sample/hold, N-step binary search
// and result capture. Define SAR_CTRL_OVERRUN_EN to abort on early sample edges.
`timescale 1ns/1ps
module sar_ctrl
  import sar_ctrl_pkg::*;
#(
  parameter int N = SAR_N_DEFAULT
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         clk_sample,
  input  logic         clk_sar,
  input  logic         cmp_in,
  input  logic         overrun_clr,
  output logic         sample_hold,
  output logic [N-1:0] dac_code,
  output logic [N-1:0] data_out,
  output logic         data_valid,
  output logic         busy,
  output logic         overrun
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_MSB = IW'(N - 1);
  localparam logic [N-1:0]  DAC_MSB = {1'b1, {(N-1){1'b0}}};

  sar_state_t    r_state, w_state_nx;
  logic [IW-1:0] r_idx, w_idx_nx;
  logic          r_sample_hold, w_sample_hold_nx;
  logic [N-1:0]  r_dac, w_dac_nx;
  logic [N-1:0]  r_data, w_data_nx;
  logic          r_valid, w_valid_nx;
  logic          r_busy, w_busy_nx;
  logic [N-1:0]  w_trial;

  logic w_smp_rise, w_smp_fall;
  logic w_sar_rise, w_unused_sar_fall;
  logic w_abort;

  edge_detect u_smp_edge (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .i_level (clk_sample),
    .o_rise  (w_smp_rise),
    .o_fall  (w_smp_fall)
  );

  edge_detect u_sar_edge (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .i_level (clk_sar),
    .o_rise  (w_sar_rise),
    .o_fall  (w_unused_sar_fall)
  );

`ifdef SAR_CTRL_OVERRUN_EN
  logic r_overrun;

  assign w_abort = (r_state == ST_CONVERT) && w_smp_rise;

  // A new abort event takes priority over a simultaneous clear.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_abort) begin
      r_overrun <= 1'b1;
    end else if (overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign overrun = r_overrun;
`else
  logic w_unused_clr;

  assign w_abort      = 1'b0;
  assign w_unused_clr = overrun_clr;
  assign overrun      = 1'b0;
`endif

  // Current decision written into bit i, next lower bit set as the new trial.
  always_comb begin
    w_trial = r_dac;
    w_trial[r_idx] = cmp_in;
    if (r_idx != '0) begin
      w_trial[r_idx - 1'b1] = 1'b1;
    end
  end

  always_comb begin
    w_state_nx       = r_state;
    w_idx_nx         = r_idx;
    w_sample_hold_nx = r_sample_hold;
    w_dac_nx         = r_dac;
    w_data_nx        = r_data;
    w_valid_nx       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_smp_rise) begin
          w_state_nx       = ST_SAMPLE;
          w_sample_hold_nx = 1'b1;
          w_dac_nx         = '0;
        end
      end
      ST_SAMPLE: begin
        if (w_smp_fall) begin
          w_state_nx       = ST_CONVERT;
          w_sample_hold_nx = 1'b0;
          w_idx_nx         = IDX_MSB;
          w_dac_nx         = DAC_MSB;
        end
      end
      ST_CONVERT: begin
        if (w_abort) begin
          w_state_nx       = ST_SAMPLE;
          w_sample_hold_nx = 1'b1;
          w_dac_nx         = '0;
        end else if (w_sar_rise) begin
          w_dac_nx = w_trial;
          if (r_idx == '0) begin
            w_state_nx = ST_DONE;
            w_data_nx  = w_trial;
            w_valid_nx = 1'b1;
          end else begin
            w_idx_nx = r_idx - 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (w_smp_rise) begin
          w_state_nx       = ST_SAMPLE;
          w_sample_hold_nx = 1'b1;
          w_dac_nx         = '0;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
    w_busy_nx = (w_state_nx == ST_SAMPLE) || (w_state_nx == ST_CONVERT);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_sample_hold <= 1'b0;
      r_dac         <= '0;
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_idx         <= w_idx_nx;
      r_sample_hold <= w_sample_hold_nx;
      r_dac         <= w_dac_nx;
      r_data        <= w_data_nx;
      r_valid       <= w_valid_nx;
      r_busy        <= w_busy_nx;
    end
  end

  assign sample_hold = r_sample_hold;
  assign dac_code    = r_dac;
  assign data_out    = r_data;
  assign data_valid  = r_valid;
  assign busy        = r_busy;

endmodule
